// File: rtl/prog_clkdiv.sv
// prog_clkdiv: multi-channel programmable tick / square-wave divider.
//
// Each channel counts system clocks up to its divisor and emits a one-cycle tick
// per period. In square mode it also drives a square wave. New divisor and mode
// values are held in a shadow register and only take effect at the channel's
// terminal count, or at a synchronous restart. This keeps the outputs free of
// glitches.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   en         per-channel count enable
//   sync       synchronous restart of all channels (applies pending shadows)
//   cfg_valid  config write request
//   cfg_ready  write can be accepted (low while the target channel has a pending write)
//   cfg_ch     target channel
//   cfg_div    new divisor (1..2**W-1)
//   cfg_mode   0 = tick mode, 1 = square mode
//   cfg_err    one-cycle pulse on a rejected write (zero divisor or bad channel)
//   tick       per-channel one-cycle pulse, once per period
//   sq         per-channel square wave (square mode only, else 0)
module prog_clkdiv #(
  parameter int unsigned NCH     = 4,
  parameter int unsigned W       = 26,
  parameter int unsigned DEF_DIV = 25000000,
  localparam int unsigned CW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] en,
  input  logic           sync,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [CW-1:0]  cfg_ch,
  input  logic [W-1:0]   cfg_div,
  input  logic           cfg_mode,
  output logic           cfg_err,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] sq
);

  logic [NCH-1:0][W-1:0] cnt_q, cnt_d;
  logic [NCH-1:0][W-1:0] div_q, div_d;
  logic [NCH-1:0][W-1:0] shd_div_q, shd_div_d;
  logic [NCH-1:0]        mode_q, mode_d;
  logic [NCH-1:0]        shd_mode_q, shd_mode_d;
  logic [NCH-1:0]        pend_q, pend_d;
  logic [NCH-1:0]        tick_q, tick_d;
  logic [NCH-1:0]        sq_q, sq_d;
  logic                  cfg_err_q, cfg_err_d;

  logic [31:0] ch_ext;
  logic        ch_ok;
  logic        div_ok;
  logic        wr_ok;

  // Config handshake. An out-of-range channel has no pending bit, so it is always
  // ready and gets accepted, then flagged as an error.
  always_comb begin
    ch_ext    = 32'(cfg_ch);
    ch_ok     = (ch_ext < NCH);
    div_ok    = (cfg_div != '0);
    cfg_ready = 1'b1;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (ch_ext == i && pend_q[i]) cfg_ready = 1'b0;
    end
    wr_ok     = cfg_valid && cfg_ready && ch_ok && div_ok;
    cfg_err_d = cfg_valid && cfg_ready && !(ch_ok && div_ok);
  end

  // Per-channel counter, output and shadow-apply logic.
  always_comb begin
    logic         tc;
    logic [W-1:0] half_m1;
    logic         apply;
    for (int unsigned i = 0; i < NCH; i++) begin
      cnt_d[i]      = cnt_q[i];
      div_d[i]      = div_q[i];
      mode_d[i]     = mode_q[i];
      shd_div_d[i]  = shd_div_q[i];
      shd_mode_d[i] = shd_mode_q[i];
      pend_d[i]     = pend_q[i];
      tick_d[i]     = 1'b0;
      sq_d[i]       = sq_q[i];

      tc      = (cnt_q[i] == div_q[i] - W'(1));
      // For div==1, half-1 wraps to all-ones. It is never reached because tc wins every cycle.
      half_m1 = (div_q[i] >> 1) - W'(1);
      apply   = 1'b0;

      if (sync) begin
        cnt_d[i] = '0;
        sq_d[i]  = 1'b0;
        apply    = pend_q[i];
      end else if (en[i]) begin
        if (tc) begin
          cnt_d[i]  = '0;
          tick_d[i] = 1'b1;
          sq_d[i]   = 1'b0;
          apply     = pend_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + W'(1);
          if (mode_q[i] && cnt_q[i] == half_m1) sq_d[i] = 1'b1;
        end
      end else if (pend_q[i]) begin
        // A disabled channel has no terminal count to wait for. Apply now and
        // restart the count so it stays below the new divisor.
        cnt_d[i] = '0;
        sq_d[i]  = 1'b0;
        apply    = 1'b1;
      end

      if (apply) begin
        div_d[i]  = shd_div_q[i];
        mode_d[i] = shd_mode_q[i];
        pend_d[i] = 1'b0;
      end

      // A channel is never pending when it accepts, so this cannot collide with apply.
      if (wr_ok && ch_ext == i) begin
        shd_div_d[i]  = cfg_div;
        shd_mode_d[i] = cfg_mode;
        pend_d[i]     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      div_q      <= {NCH{W'(DEF_DIV)}};
      shd_div_q  <= {NCH{W'(DEF_DIV)}};
      mode_q     <= '0;
      shd_mode_q <= '0;
      pend_q     <= '0;
      tick_q     <= '0;
      sq_q       <= '0;
      cfg_err_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      shd_div_q  <= shd_div_d;
      mode_q     <= mode_d;
      shd_mode_q <= shd_mode_d;
      pend_q     <= pend_d;
      tick_q     <= tick_d;
      sq_q       <= sq_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign tick    = tick_q;
  assign sq      = sq_q;
  assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_prog_clkdiv.sv
// Directed bench for prog_clkdiv. The main instance uses NCH=2, W=8, DEF_DIV=4.
// A second instance with NCH=3 covers out-of-range channel writes.
// Each channel's expected tick/sq comes from its period, its start cycle and its mode.
module tb_prog_clkdiv;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [1:0] en;
  logic       sync;
  logic       cfg_valid;
  logic       cfg_ready;
  logic       cfg_ch;
  logic [7:0] cfg_div;
  logic       cfg_mode;
  logic       cfg_err;
  logic [1:0] tick;
  logic [1:0] sq;

  logic [2:0] en3;
  logic       sync3;
  logic       valid3;
  logic       rdy3;
  logic [1:0] ch3;
  logic [7:0] div3;
  logic       mode3;
  logic       err3;
  logic [2:0] tick3;
  logic [2:0] sq3;

  prog_clkdiv #(.NCH(2), .W(8), .DEF_DIV(4)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .sync      (sync),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_mode  (cfg_mode),
    .cfg_err   (cfg_err),
    .tick      (tick),
    .sq        (sq)
  );

  prog_clkdiv #(.NCH(3), .W(8), .DEF_DIV(4)) u_dut3 (
    .clk       (clk),
    .rst       (rst),
    .en        (en3),
    .sync      (sync3),
    .cfg_valid (valid3),
    .cfg_ready (rdy3),
    .cfg_ch    (ch3),
    .cfg_div   (div3),
    .cfg_mode  (mode3),
    .cfg_err   (err3),
    .tick      (tick3),
    .sq        (sq3)
  );

  int n_checks;
  int n_fail;
  int cyc;
  int per  [2];
  int base [2];
  bit sqm  [2];
  int base3;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  // Advance n cycles and check both channels of u_dut plus channels 0/1 of u_dut3.
  task automatic run(input int n);
    int p;
    for (int k = 0; k < n; k++) begin
      step();
      for (int c = 0; c < 2; c++) begin
        p = (cyc - base[c]) % per[c];
        check_eq($sformatf("tick%0d@%0d", c, cyc), 32'(tick[c]), 32'(p == 0));
        check_eq($sformatf("sq%0d@%0d", c, cyc), 32'(sq[c]),
                 32'(sqm[c] && per[c] >= 2 && p >= per[c] / 2));
      end
      p = (cyc - base3) % 4;
      check_eq($sformatf("tick3@%0d", cyc), 32'(tick3[1:0]), (p == 0) ? 32'd3 : 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; en = '0; sync = 1'b0; cfg_valid = 1'b0; cfg_ch = 1'b0;
    cfg_div = '0; cfg_mode = 1'b0;
    en3 = '0; sync3 = 1'b0; valid3 = 1'b0; ch3 = '0; div3 = '0; mode3 = 1'b0;
    n_checks = 0; n_fail = 0; cyc = 0;
    repeat (2) @(negedge clk);

    // Reset state
    check_eq("rst_tick", 32'(tick), 32'd0);
    check_eq("rst_sq", 32'(sq), 32'd0);
    check_eq("rst_err", 32'(cfg_err), 32'd0);
    check_eq("rst_ready", 32'(cfg_ready), 32'd1);
    check_eq("rst_tick3", 32'(tick3), 32'd0);
    check_eq("rst_sq3", 32'(sq3), 32'd0);

    // Default divisor 4: ticks on cycles 4, 8, 12
    rst = 1'b0; en = 2'b11; en3 = 3'b111;
    per = '{4, 4}; base = '{0, 0}; sqm = '{0, 0}; base3 = 0;
    run(13);

    // ch0 -> div 6 square, written at cnt==1; old period completes at cycle 16
    cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_div = 8'd6; cfg_mode = 1'b1; #1;
    check_eq("wr0_ready_idle", 32'(cfg_ready), 32'd1);
    run(1);
    cfg_valid = 1'b0; #1;
    check_eq("wr0_ready_pend", 32'(cfg_ready), 32'd0);
    run(1);
    check_eq("wr0_ready_pend2", 32'(cfg_ready), 32'd0);
    run(1);
    check_eq("wr0_ready_done", 32'(cfg_ready), 32'd1);
    per[0] = 6; base[0] = cyc; sqm[0] = 1'b1;
    run(12);

    // ch1 -> div 5 square: 2 low / 3 high
    cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_div = 8'd5; cfg_mode = 1'b1;
    run(1);
    cfg_valid = 1'b0; #1;
    check_eq("wr1_ready_pend", 32'(cfg_ready), 32'd0);
    run(3);
    check_eq("wr1_ready_done", 32'(cfg_ready), 32'd1);
    per[1] = 5; base[1] = cyc; sqm[1] = 1'b1;
    run(10);

    // ch1 -> div 1: tick constantly high, sq stays 0
    cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_div = 8'd1; cfg_mode = 1'b1;
    run(1);
    cfg_valid = 1'b0; #1;
    check_eq("wr1b_ready_pend", 32'(cfg_ready), 32'd0);
    run(4);
    per[1] = 1; base[1] = cyc;
    run(5);

    // Zero divisor is rejected: one-cycle error, ch0 keeps period 6
    cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_div = 8'd0; cfg_mode = 1'b0; #1;
    check_eq("div0_ready", 32'(cfg_ready), 32'd1);
    run(1);
    cfg_valid = 1'b0; #1;
    check_eq("div0_err", 32'(cfg_err), 32'd1);
    check_eq("div0_ready_after", 32'(cfg_ready), 32'd1);
    run(1);
    check_eq("div0_err_clear", 32'(cfg_err), 32'd0);

    // Out-of-range channel on the 3-channel instance; channel 2 itself is valid
    valid3 = 1'b1; ch3 = 2'd3; div3 = 8'd2; #1;
    check_eq("ch3_ready", 32'(rdy3), 32'd1);
    run(1);
    check_eq("ch3_err", 32'(err3), 32'd1);
    ch3 = 2'd2;
    run(1);
    check_eq("ch2_no_err", 32'(err3), 32'd0);
    valid3 = 1'b0; #1;
    check_eq("ch2_ready_pend", 32'(rdy3), 32'd0);
    run(6);

    // Freeze ch0 for 10 cycles at cnt==4 (sq high), then resume where it stopped
    en[0] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      check_eq($sformatf("frz_tick0@%0d", cyc), 32'(tick[0]), 32'd0);
      check_eq($sformatf("frz_sq0@%0d", cyc), 32'(sq[0]), 32'd1);
      check_eq($sformatf("frz_tick1@%0d", cyc), 32'(tick[1]), 32'd1);
    end
    en[0] = 1'b1; base[0] = base[0] + 10;
    run(8);

    // sync with ch0 pending (div 3) and a ch1 write (div 4) accepted on the same edge
    cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_div = 8'd3; cfg_mode = 1'b0;
    run(1);
    cfg_ch = 1'b1; cfg_div = 8'd4; cfg_mode = 1'b0; sync = 1'b1;
    step();
    cfg_valid = 1'b0; sync = 1'b0; #1;
    check_eq("sync_tick", 32'(tick), 32'd0);
    check_eq("sync_sq", 32'(sq), 32'd0);
    check_eq("sync_ready1_pend", 32'(cfg_ready), 32'd0);
    cfg_ch = 1'b0; #1;
    check_eq("sync_ready0_applied", 32'(cfg_ready), 32'd1);
    per[0] = 3; base[0] = cyc; sqm[0] = 1'b0;
    run(1);
    per[1] = 4; base[1] = cyc; sqm[1] = 1'b0;
    run(8);

    // Reset at ch0 cnt==2 with a write pending: pending discarded, divisor back to 4
    cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_div = 8'd5; cfg_mode = 1'b1;
    run(1);
    cfg_valid = 1'b0;
    run(1);
    check_eq("rst_pend_ready", 32'(cfg_ready), 32'd0);
    rst = 1'b1; #1;
    check_eq("rst2_tick", 32'(tick), 32'd0);
    check_eq("rst2_sq", 32'(sq), 32'd0);
    check_eq("rst2_err", 32'(cfg_err), 32'd0);
    check_eq("rst2_ready", 32'(cfg_ready), 32'd1);
    check_eq("rst2_tick3", 32'(tick3), 32'd0);
    check_eq("rst2_rdy3", 32'(rdy3), 32'd1);
    repeat (2) step();
    rst = 1'b0;
    per = '{4, 4}; base = '{cyc, cyc}; sqm = '{0, 0}; base3 = cyc;
    run(12);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
